// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared Full_adder cell, one bit per clock, LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow output Ovf_out.

module Full_adder (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic Sum,
   output logic Cout
);
   assign Sum  = A ^ B ^ C;
   assign Cout = (A & B) | (C & (A ^ B));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum_out,
`ifdef SERIAL_ADD_OVF_EN
   output logic             Cout_out,
   output logic             Ovf_out
`else
   output logic             Cout_out
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             fa_sum, fa_cout;
   logic             last_bit;

   // The LSB of acc is always shifted out before the result is taken.
   logic             unused_acc_lsb;
   assign unused_acc_lsb = acc_q[0];

   Full_adder u_fa (
      .A   (opa_q[0]),
      .B   (opb_q[0]),
      .C   (carry_q),
      .Sum (fa_sum),
      .Cout(fa_cout)
   );

   assign last_bit = (cnt_q == LAST_BIT);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_bit) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   // NOTE: every _d gets a hold default first so no path through the case infers a latch.
   always_comb begin
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               opa_d   = A_in;
               opb_d   = B_in;
               carry_d = Cin;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
            carry_d = fa_cout;
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               sum_d  = {fa_sum, acc_q[WIDTH-1:1]};
               cout_d = fa_cout;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign Sum_out  = sum_q;
   assign Cout_out = cout_q;

`ifdef SERIAL_ADD_OVF_EN
   // Carry into the MSB differs from carry out of it exactly on two's-complement overflow.
   logic ovf_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           ovf_q <= 1'b0;
      else if (state_q == S_RUN && last_bit) ovf_q <= carry_q ^ fa_cout;
   end
   assign Ovf_out = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random additions against an arithmetic model.
// Define SERIAL_ADD_OVF_EN to also exercise Ovf_out.

module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] A_in = '0;
   logic [W-1:0] B_in = '0;
   logic         Cin = 1'b0;
   logic         busy, done, Cout_out;
   logic [W-1:0] Sum_out;
`ifdef SERIAL_ADD_OVF_EN
   logic         Ovf_out;
`endif

   int total = 0;
   int bad   = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .A_in    (A_in),
      .B_in    (B_in),
      .Cin     (Cin),
      .busy    (busy),
      .done    (done),
      .Sum_out (Sum_out),
`ifdef SERIAL_ADD_OVF_EN
      .Cout_out(Cout_out),
      .Ovf_out (Ovf_out)
`else
      .Cout_out(Cout_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Signed overflow: true sum of the signed operands plus carry falls outside the W-bit range.
   function automatic bit ovf_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int sa, sb, s;
      sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
      s  = sa + sb + int'(c);
      return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
   endfunction

   // Inputs are driven 1 time unit after a rising edge; outputs are sampled there too.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] expv;
      int         early;
      expv  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      early = 0;
      A_in = a; B_in = b; Cin = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      A_in = W'($urandom); B_in = W'($urandom); Cin = 1'($urandom);
      check("busy_after_accept", busy, 1);
      check("done_after_accept", done, 0);
      for (int i = 1; i < W; i++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b1) early++;
      end
      check("run_phase_flags", early, 0);
      @(posedge clk); #1;
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 1);
      check("sum", Sum_out, expv[W-1:0]);
      check("cout", Cout_out, expv[W]);
`ifdef SERIAL_ADD_OVF_EN
      check("ovf", Ovf_out, ovf_model(a, b, c));
`endif
      @(posedge clk); #1;
      check("busy_after_done", busy, 0);
      check("done_single_cycle", done, 0);
      check("sum_hold", Sum_out, expv[W-1:0]);
   endtask

   initial begin
      int         ndone;
      logic [W-1:0] seen_sum;
      int         q[$];

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", Sum_out, 0);
      check("rst_cout", Cout_out, 0);
`ifdef SERIAL_ADD_OVF_EN
      check("rst_ovf", Ovf_out, 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed values
      run_op(8'h5A, 8'h3C, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1);
      run_op(8'h00, 8'h00, 1'b0);
      run_op(8'h00, 8'h00, 1'b1);

      // Random values
      for (int k = 0; k < 24; k++)
         run_op(W'($urandom), W'($urandom), 1'($urandom));

      // Second request during RUN is ignored and mid-run operand changes do not matter
      A_in = 8'h10; B_in = 8'h20; Cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; A_in = 8'hAA; B_in = 8'h55;
      @(posedge clk); #1;
      start = 1'b0; A_in = 8'hFF;
      ndone = 0; seen_sum = '0;
      for (int c = 4; c <= W + 8; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            ndone++;
            seen_sum = Sum_out;
         end
      end
      check("ignore_done_count", ndone, 1);
      check("ignore_sum", seen_sum, 8'h30);
      check("ignore_busy_end", busy, 0);

      // Reset in mid-operation aborts immediately
      A_in = 8'h0F; B_in = 8'h01; Cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sum", Sum_out, 0);
      check("abort_cout", Cout_out, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < W + 4; c++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) ndone++;
      end
      check("abort_no_activity", ndone, 0);
      run_op(8'h0F, 8'h01, 1'b0);

      // start held high: one result every W+2 cycles
      A_in = 8'h33; B_in = 8'h44; Cin = 1'b1; start = 1'b1;
      ndone = 0;
      for (int c = 0; c < 4 * (W + 2); c++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            q.push_back(c);
            if (Sum_out !== 8'h78 || Cout_out !== 1'b0) ndone++;
         end
      end
      start = 1'b0;
      check("held_done_count", q.size(), 4);
      check("held_result_errors", ndone, 0);
      if (q.size() == 4) begin
         check("held_first_done", q[0], W);
         for (int i = 1; i < 4; i++)
            check("held_period", q[i] - q[i-1], W + 2);
      end
      repeat (W + 3) @(posedge clk);
      #1;
      check("held_drained", busy, 0);

`ifdef SERIAL_ADD_OVF_EN
      run_op(8'h7F, 8'h01, 1'b0);
      check("ovf_7f_sum", Sum_out, 8'h80);
      check("ovf_7f_flag", Ovf_out, 1);
      run_op(8'h80, 8'h80, 1'b0);
      check("ovf_80_flag", Ovf_out, 1);
      check("ovf_80_cout", Cout_out, 1);
      run_op(8'h05, 8'h03, 1'b0);
      check("ovf_05_flag", Ovf_out, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
